simon_byte_io: RTL and testbench

SIMON_BYTE_IO -- requirements
Module: simon_byte_io

---
 rtl/simon_byte_io.sv | 187 ++++++++++++++++++
 tb/tb_simon_byte_io.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_byte_io.sv
// Byte-serial front end for a SIMON 32/64 core: collects a 12-byte key+block frame,
// runs the cipher with a cycle timeout, and streams the 4-byte result back out.
module simon_byte_io #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_mode,
    output logic        in_ready,

    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,

    output logic        err,

    output logic        wait_data,
    output logic        cryp_decryp,
    output logic [15:0] k_in [3:0],
    output logic [15:0] text_in [1:0],
    input  logic        done,
    input  logic [15:0] crypt_out [1:0]
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] CYC_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  BYTE_LAST = 4'd11;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  byte_cnt;
    logic [15:0] cyc_cnt;
    logic [1:0]  out_idx;
    logic [95:0] frame;
    logic [31:0] result;

    logic in_fire;
    logic out_fire;
    logic timeout_hit;

    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    assign timeout_hit = (cyc_cnt == CYC_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        wait_data = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == BYTE_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                wait_data = 1'b0;
                // done wins over a timeout landing in the same cycle
                if (done) begin
                    state_nx = DRAIN;
                end else if (timeout_hit) begin
                    state_nx = LOAD;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && out_idx == 2'd3) begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    // Frame byte counter; wraps to 0 on the byte-11 handshake, i.e. on entry to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if (in_fire) begin
            byte_cnt <= (byte_cnt == BYTE_LAST) ? 4'd0 : byte_cnt + 4'd1;
        end
    end

    // NOTE: the frame register feeds the cipher operands directly, so unlike a
    // plain storage array it is reset to give defined k_in/text_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame <= '0;
        end else if (in_fire) begin
            for (int b = 0; b < 12; b++) begin
                if (byte_cnt == 4'(b)) begin
                    frame[95 - 8*b -: 8] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cryp_decryp <= 1'b1;
        end else if (in_fire && byte_cnt == 4'd0) begin
            cryp_decryp <= in_mode;
        end
    end

    // Cycle counter restarts from 0 every time RUN is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (state == RUN) begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end else begin
            cyc_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (state == RUN && done) begin
            result <= {crypt_out[1], crypt_out[0]};
        end
    end

    // Sticky until the first byte of the following frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == RUN && !done && timeout_hit) begin
            err <= 1'b1;
        end else if (in_fire && byte_cnt == 4'd0) begin
            err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx <= '0;
        end else if (out_fire) begin
            out_idx <= out_idx + 2'd1;
        end
    end

    always_comb begin
        out_data = 8'h00;
        if (state == DRAIN) begin
            case (out_idx)
                2'd0:    out_data = result[31:24];
                2'd1:    out_data = result[23:16];
                2'd2:    out_data = result[15:8];
                default: out_data = result[7:0];
            endcase
        end
    end

    assign out_last = (state == DRAIN) && (out_idx == 2'd3);

    assign k_in[3]    = frame[95:80];
    assign k_in[2]    = frame[79:64];
    assign k_in[1]    = frame[63:48];
    assign k_in[0]    = frame[47:32];
    assign text_in[1] = frame[31:16];
    assign text_in[0] = frame[15:0];

endmodule

// File: tb/tb_simon_byte_io.sv
// Directed bench for simon_byte_io with a behavioural SIMON 32/64 core of
// configurable latency and a byte scoreboard for the result stream.
module tb_simon_byte_io;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_mode;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        err;
    logic        wait_data;
    logic        cryp_decryp;
    logic [15:0] k_in [3:0];
    logic [15:0] text_in [1:0];
    logic        done;
    logic [15:0] crypt_out [1:0];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [7:0]  byte_q [$];

    // cipher model: done rises done_at cycles after wait_data falls
    int          run_cnt = 0;
    int          done_at = 3;
    logic [31:0] model_r;

    localparam logic [63:0] KEY_A = 64'h1918_1110_0908_0100;
    localparam logic [31:0] PT_A  = 32'h6565_6877;
    localparam logic [31:0] CT_A  = 32'hc69b_e9bb;

    simon_byte_io #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .err        (err),
        .wait_data  (wait_data),
        .cryp_decryp(cryp_decryp),
        .k_in       (k_in),
        .text_in    (text_in),
        .done       (done),
        .crypt_out  (crypt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rol(input logic [15:0] x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    function automatic logic [15:0] fr(input logic [15:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic [31:0] simon(input logic [63:0] key, input logic [31:0] blk,
                                          input logic enc);
        logic [15:0] k [32];
        logic [15:0] x, y, t;
        logic [30:0] z;
        z    = 31'b1111101000100101011000011100110;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 4; i < 32; i++) begin
            t    = rol(k[i-1], 13) ^ k[i-3];
            t    = t ^ rol(t, 15);
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[30 - ((i - 4) % 31)]} ^ 16'd3;
        end
        x = blk[31:16];
        y = blk[15:0];
        if (enc) begin
            for (int i = 0; i < 32; i++) begin
                t = x;
                x = y ^ fr(x) ^ k[i];
                y = t;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                t = y;
                y = x ^ fr(y) ^ k[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    always @(posedge clk) begin
        if (wait_data) run_cnt <= 0;
        else           run_cnt <= run_cnt + 1;
    end

    assign model_r = simon({k_in[3], k_in[2], k_in[1], k_in[0]}, {text_in[1], text_in[0]},
                           cryp_decryp);

    always_comb begin
        done         = !wait_data && (run_cnt == done_at);
        crypt_out[1] = done ? model_r[31:16] : 16'hdead;
        crypt_out[0] = done ? model_r[15:0]  : 16'hbeef;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " wait_data"},   wait_data,   1);
        check({tag, " cryp_decryp"}, cryp_decryp, 1);
        check({tag, " k_in"},        {k_in[3], k_in[2], k_in[1], k_in[0]}, 0);
        check({tag, " text_in"},     {text_in[1], text_in[0]}, 0);
        check({tag, " out_valid"},   out_valid,   0);
        check({tag, " out_data"},    out_data,    0);
        check({tag, " out_last"},    out_last,    0);
        check({tag, " err"},         err,         0);
    endtask

    task automatic push_result(input logic [31:0] r);
        byte_q.push_back(r[31:24]);
        byte_q.push_back(r[23:16]);
        byte_q.push_back(r[15:8]);
        byte_q.push_back(r[7:0]);
    endtask

    // Called at a negedge; returns at the negedge after the last handshake.
    task automatic send_frame(input logic [95:0] f, input logic mode, input int nbytes);
        int guard;
        for (int i = 0; i < nbytes; i++) begin
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("in_ready in LOAD", in_ready, 1);
            in_valid = 1'b1;
            in_data  = f[95 - 8*i -: 8];
            in_mode  = (i == 0) ? mode : ~mode;
            @(negedge clk);
            if (i == 0) check("err after byte0", err, 0);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic drain(input int stall_at, input int stall_len);
        int guard;
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (!out_valid && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("out_valid in DRAIN", out_valid, 1);
            check("scoreboard has entry", byte_q.size() > 0, 1);
            exp = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hxx;
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("stall out_data", out_data, exp);
                    check("stall in_ready", in_ready, 0);
                end
            end
            check("out_data", out_data, exp);
            check("out_last", out_last, (i == 3));
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("out_valid after last", out_valid, 0);
        check("in_ready after last",  in_ready,  1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] key;
        logic [31:0] txt;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", in_ready, 1);

        // known-answer encrypt with output latency check
        done_at = 3;
        push_result(CT_A);
        send_frame({KEY_A, PT_A}, 1'b1, 12);
        check("wait_data falls N+1", wait_data, 0);
        check("in_ready low in RUN", in_ready, 0);
        check("cryp_decryp enc", cryp_decryp, 1);
        check("k_in mapping", {k_in[3], k_in[2], k_in[1], k_in[0]}, KEY_A);
        check("text_in mapping", {text_in[1], text_in[0]}, PT_A);
        repeat (3) @(negedge clk);
        check("no out_valid during done cycle", out_valid, 0);
        check("operands held in RUN", {text_in[1], text_in[0]}, PT_A);
        @(negedge clk);
        check("out_valid at M+1", out_valid, 1);
        check("wait_data back high", wait_data, 1);
        drain(-1, 0);
        check("err after encrypt", err, 0);

        // known-answer decrypt
        push_result(PT_A);
        send_frame({KEY_A, CT_A}, 1'b0, 12);
        check("cryp_decryp dec", cryp_decryp, 0);
        drain(-1, 0);

        // downstream stall on byte 1
        push_result(CT_A);
        send_frame({KEY_A, PT_A}, 1'b1, 12);
        drain(1, 5);

        // cipher never answers: timeout
        done_at = 1000;
        send_frame({KEY_A, PT_A}, 1'b1, 12);
        check("timeout wait_data low", wait_data, 0);
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            check("timeout err pending", err, 0);
            check("timeout no out_valid", out_valid, 0);
        end
        @(negedge clk);
        check("timeout err set", err, 1);
        check("timeout in_ready", in_ready, 1);
        check("timeout out_valid", out_valid, 0);
        repeat (3) @(negedge clk);
        check("err sticky", err, 1);

        // next frame clears err (checked after byte 0 inside send_frame)
        done_at = 3;
        key = {$urandom, $urandom};
        txt = $urandom;
        push_result(simon(key, txt, 1'b1));
        send_frame({key, txt}, 1'b1, 12);
        drain(-1, 0);

        // done lands exactly in the timeout cycle
        done_at = 7;
        key = {$urandom, $urandom};
        txt = $urandom;
        push_result(simon(key, txt, 1'b0));
        send_frame({key, txt}, 1'b0, 12);
        repeat (8) @(negedge clk);
        check("done-at-timeout DRAIN", out_valid, 1);
        check("done-at-timeout err", err, 0);
        drain(-1, 0);

        // reset in the middle of LOAD
        done_at = 3;
        send_frame({KEY_A, CT_A}, 1'b0, 6);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid-load reset");
        check("mid-load reset in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        push_result(CT_A);
        send_frame({KEY_A, PT_A}, 1'b1, 12);
        drain(-1, 0);

        // reset in the middle of DRAIN discards the pending result
        send_frame({KEY_A, PT_A}, 1'b1, 12);
        repeat (4) @(negedge clk);
        check("pre-reset DRAIN", out_valid, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid-drain reset");
        @(negedge clk);
        rst = 1'b0;
        push_result(PT_A);
        send_frame({KEY_A, CT_A}, 1'b0, 12);
        drain(-1, 0);
        check("scoreboard empty", byte_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
